// File: rtl/exec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exec_sequencer_pkg
//
// Shared definitions for the instruction sequencer and its sub-module.
//   - Default datapath widths (register width, register address width,
//     opcode width) and the width of the one-hot unit-enable bus.
//   - Opcode constants OP_NOP .. OP_NOT. The value of each opcode is also the
//     bit index of its function-unit enable.
//   - Sequencer state encoding S_IDLE / S_READ / S_EXEC / S_WRITE.
//   - op_is_write(): tells whether an opcode produces a register write-back.
// -----------------------------------------------------------------------------
package exec_sequencer_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_OP_W   = 3;
    localparam int UNIT_W     = 8;

    localparam logic [DEF_OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [DEF_OP_W-1:0] OP_COPY = 3'd1;
    localparam logic [DEF_OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [DEF_OP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [DEF_OP_W-1:0] OP_AND  = 3'd4;
    localparam logic [DEF_OP_W-1:0] OP_OR   = 3'd5;
    localparam logic [DEF_OP_W-1:0] OP_XOR  = 3'd6;
    localparam logic [DEF_OP_W-1:0] OP_NOT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // NOP is the only opcode that retires without touching the register file.
    function automatic logic op_is_write(input logic [DEF_OP_W-1:0] op);
        return (op != OP_NOP);
    endfunction

endpackage

// File: rtl/exec_sequencer_op_decoder.sv
// -----------------------------------------------------------------------------
// op_decoder
//
// Turns an opcode into the one-hot function-unit enable vector. Bit index of
// the enable equals the opcode value. NOP (opcode 0) has no unit, so bit 0 is
// never set. The whole vector is forced to zero while en is low, so the
// sequencer can gate unit activity to a single cycle.
//
// Ports:
//   en       in   1        decoder enable (high only during EXEC)
//   op       in   OP_W     opcode to decode
//   unit_en  out  UNIT_W   one-hot unit enable, all-zero for NOP or en=0
// -----------------------------------------------------------------------------
module op_decoder
    import exec_sequencer_pkg::*;
#(
    parameter int OP_W = DEF_OP_W
) (
    input  logic            en,
    input  logic [OP_W-1:0] op,
    output logic [UNIT_W-1:0] unit_en
);

    // NOP has no function unit behind it.
    assign unit_en[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < UNIT_W; gi++) begin : g_dec
            assign unit_en[gi] = en && (op == OP_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Four-cycle instruction sequencer for the register-file / function-unit
// datapath. One instruction is accepted per visit to IDLE; it then walks
// READ -> EXEC -> WRITE and returns to IDLE.
//
//   cycle 0  accept edge (instr_valid & instr_ready in IDLE)
//   cycle 1  READ : register file addressed with src1/src2, operands latched
//   cycle 2  EXEC : one unit enabled, its result latched
//   cycle 3  WRITE: rf_we (unless NOP), done pulse, retire counter bumps
//   cycle 4  IDLE : instr_ready high again
//
// Configuration macro: EXEC_COUNT_EN
//   defined   -> instr_count counts retired instructions (NOP included),
//                wrapping 255 -> 0
//   undefined -> no counter; instr_count is tied to zero
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instr_valid / instr_ready  instruction handshake (ready only in IDLE)
//   instr_op/dst/src1/src2     instruction fields, sampled on accept
//   rf_raddr1/2, rf_rdata1/2   register-file read port (combinational read)
//   unit_en                    one-hot function-unit enable, index = opcode
//   unit_rd1/2                 latched operands shared by all units
//   unit_result                result of the enabled unit (combinational)
//   rf_we, rf_waddr, rf_wdata  register-file write port
//   done                       one-cycle pulse per retired instruction
//   instr_count                retired-instruction counter
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic [ADDR_W-1:0] instr_src1,
    input  logic [ADDR_W-1:0] instr_src2,

    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,

    output logic [UNIT_W-1:0] unit_en,
    output logic [DATA_W-1:0] unit_rd1,
    output logic [DATA_W-1:0] unit_rd2,
    input  logic [DATA_W-1:0] unit_result,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic [7:0]        instr_count
);

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   accept;

    assign accept = (state_q == S_IDLE) && instr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed walk through the four states; instr_valid only matters in IDLE,
    // so offers made while busy are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Instruction latch
    // -------------------------------------------------------------------------
    logic [OP_W-1:0]   op_q,   op_d;
    logic [ADDR_W-1:0] dst_q,  dst_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;

    always_comb begin
        op_d   = op_q;
        dst_d  = dst_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (accept) begin
            op_d   = instr_op;
            dst_d  = instr_dst;
            src1_d = instr_src1;
            src2_d = instr_src2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            dst_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            op_q   <= op_d;
            dst_q  <= dst_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand and result registers
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rd1_q,    rd1_d;
    logic [DATA_W-1:0] rd2_q,    rd2_d;
    logic [DATA_W-1:0] result_q, result_d;

    // Operands are captured in READ before anything is written back, so an
    // instruction whose destination equals one of its sources still sees the
    // old register value.
    always_comb begin
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        result_d = result_q;
        if (state_q == S_READ) begin
            rd1_d = rf_rdata1;
            rd2_d = rf_rdata2;
        end
        if (state_q == S_EXEC) begin
            result_d = unit_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q    <= '0;
            rd2_q    <= '0;
            result_q <= '0;
        end else begin
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Unit enable decode
    // -------------------------------------------------------------------------
    op_decoder #(
        .OP_W (OP_W)
    ) u_op_decoder (
        .en      (state_q == S_EXEC),
        .op      (op_q),
        .unit_en (unit_en)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign instr_ready = (state_q == S_IDLE);

    // Read addresses come straight from the latch: they show the new sources
    // in READ and hold between instructions.
    assign rf_raddr1 = src1_q;
    assign rf_raddr2 = src2_q;

    assign unit_rd1 = rd1_q;
    assign unit_rd2 = rd2_q;

    assign done     = (state_q == S_WRITE);
    assign rf_we    = (state_q == S_WRITE) && op_is_write(op_q);
    assign rf_waddr = dst_q;
    assign rf_wdata = result_q;

    // -------------------------------------------------------------------------
    // Retired-instruction counter
    // -------------------------------------------------------------------------
`ifdef EXEC_COUNT_EN
    logic [7:0] count_q, count_d;

    // Bumped on the WRITE cycle only, so an instruction aborted by reset
    // before WRITE never counts. Natural 8-bit wrap 255 -> 0.
    always_comb begin
        count_d = count_q;
        if (state_q == S_WRITE) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule
